// File: rtl/regfile_param_rd_pkg.sv
// Shared defaults for the parametrised register file and its read-port selector.
package regfile_param_rd_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 2;
endpackage

// File: rtl/regfile_param_rd_onehot_mux.sv
// One-hot AND-OR word selector: decode the address, gate each word with its
// select line, then OR everything together.
module onehot_mux #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0]                     sel_i,
    input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]    data_i,
    output logic [DATA_W-1:0]                     data_o
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] onehot;

    always_comb begin
        onehot = '0;
        for (int i = 0; i < DEPTH; i++)
            onehot[i] = (sel_i == ADDR_W'(i));
    end

    always_comb begin
        data_o = '0;
        for (int i = 0; i < DEPTH; i++)
            data_o = data_o | (data_i[i] & {DATA_W{onehot[i]}});
    end
endmodule

// File: rtl/regfile_param_rd.sv
// Flop-based register file: one write port, NUM_RD registered read ports with
// valid flags, optional hard-wired zero entry and same-edge write forwarding.
module regfile_param_rd
    import regfile_param_rd_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                       clock,
    input  logic                       ctrl_reset_n,
    input  logic                       ctrl_we,
    input  logic [ADDR_W-1:0]          ctrl_waddr,
    input  logic [DATA_W-1:0]          data_wr,
    input  logic [NUM_RD-1:0]          ctrl_rd_en,
    input  logic [NUM_RD*ADDR_W-1:0]   ctrl_raddr,
    output logic [NUM_RD*DATA_W-1:0]   data_rd,
    output logic [NUM_RD-1:0]          rd_valid
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] mem_q;
    logic                         wr_ok;

    // A write to entry 0 is dropped entirely when it is the zero register,
    // so it must not be forwarded either.
    assign wr_ok = ctrl_we && !(ZERO_REG && (ctrl_waddr == '0));

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n)
            mem_q <= '0;
        else if (wr_ok)
            mem_q[ctrl_waddr] <= data_wr;
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] raddr;
        logic [DATA_W-1:0] mux_out;
        logic [DATA_W-1:0] rd_d;
        logic [DATA_W-1:0] rd_q;
        logic              vld_q;

        assign raddr = ctrl_raddr[p*ADDR_W +: ADDR_W];

        onehot_mux #(
            .DATA_W(DATA_W),
            .ADDR_W(ADDR_W)
        ) u_mux (
            .sel_i (raddr),
            .data_i(mem_q),
            .data_o(mux_out)
        );

        always_comb begin
            rd_d = mux_out;
            if (BYPASS && wr_ok && (raddr == ctrl_waddr))
                rd_d = data_wr;
            if (ZERO_REG && (raddr == '0))
                rd_d = '0;
        end

        always_ff @(posedge clock or negedge ctrl_reset_n) begin
            if (!ctrl_reset_n) begin
                rd_q  <= '0;
                vld_q <= 1'b0;
            end else begin
                vld_q <= ctrl_rd_en[p];
                if (ctrl_rd_en[p])
                    rd_q <= rd_d;
            end
        end

        assign data_rd[p*DATA_W +: DATA_W] = rd_q;
        assign rd_valid[p]                 = vld_q;
    end
endmodule

// File: tb/tb_regfile_param_rd.sv
// Directed bench: default instance, a no-zero/no-bypass instance sharing its
// stimulus, and a 16-bit x 8-entry x 4-port instance.
module tb_regfile_param_rd;
    logic        clock = 1'b0;
    logic        ctrl_reset_n = 1'b0;

    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  rd_en;
    logic [9:0]  raddr;
    logic [63:0] a_rd, b_rd;
    logic [1:0]  a_vld, b_vld;

    logic        s_we;
    logic [2:0]  s_waddr;
    logic [15:0] s_wdata;
    logic [3:0]  s_rd_en;
    logic [11:0] s_raddr;
    logic [63:0] s_rd;
    logic [3:0]  s_vld;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    regfile_param_rd u_a (
        .clock(clock), .ctrl_reset_n(ctrl_reset_n), .ctrl_we(we), .ctrl_waddr(waddr),
        .data_wr(wdata), .ctrl_rd_en(rd_en), .ctrl_raddr(raddr), .data_rd(a_rd), .rd_valid(a_vld));

    regfile_param_rd #(.ZERO_REG(1'b0), .BYPASS(1'b0)) u_b (
        .clock(clock), .ctrl_reset_n(ctrl_reset_n), .ctrl_we(we), .ctrl_waddr(waddr),
        .data_wr(wdata), .ctrl_rd_en(rd_en), .ctrl_raddr(raddr), .data_rd(b_rd), .rd_valid(b_vld));

    regfile_param_rd #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) u_s (
        .clock(clock), .ctrl_reset_n(ctrl_reset_n), .ctrl_we(s_we), .ctrl_waddr(s_waddr),
        .data_wr(s_wdata), .ctrl_rd_en(s_rd_en), .ctrl_raddr(s_raddr), .data_rd(s_rd), .rd_valid(s_vld));

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [1:0]  re;
        logic [4:0]  ra0, ra1;
        logic [1:0]  ev;
        logic [31:0] a0, a1, b0, b1;
    } vec_t;

    vec_t tv[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        we = 1'b0; waddr = '0; wdata = '0; rd_en = '0; raddr = '0;
        s_we = 1'b0; s_waddr = '0; s_wdata = '0; s_rd_en = '0; s_raddr = '0;
    endtask

    initial begin
        //           we    wa     wd            re     ra0    ra1    ev     a0            a1            b0            b1
        tv[0]  = '{1'b0, 5'd0,  32'h0,        2'b01, 5'd7,  5'd0,  2'b01, 32'h0,        32'h0,        32'h0,        32'h0};
        tv[1]  = '{1'b1, 5'd5,  32'hDEADBEEF, 2'b00, 5'd0,  5'd0,  2'b00, 32'h0,        32'h0,        32'h0,        32'h0};
        tv[2]  = '{1'b0, 5'd0,  32'h0,        2'b11, 5'd5,  5'd5,  2'b11, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        tv[3]  = '{1'b1, 5'd0,  32'h12345678, 2'b00, 5'd0,  5'd0,  2'b00, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        tv[4]  = '{1'b0, 5'd0,  32'h0,        2'b11, 5'd0,  5'd0,  2'b11, 32'h0,        32'h0,        32'h12345678, 32'h12345678};
        tv[5]  = '{1'b1, 5'd9,  32'h1,        2'b00, 5'd0,  5'd0,  2'b00, 32'h0,        32'h0,        32'h12345678, 32'h12345678};
        tv[6]  = '{1'b1, 5'd9,  32'hA5A5A5A5, 2'b11, 5'd5,  5'd9,  2'b11, 32'hDEADBEEF, 32'hA5A5A5A5, 32'hDEADBEEF, 32'h00000001};
        tv[7]  = '{1'b0, 5'd0,  32'h0,        2'b11, 5'd0,  5'd9,  2'b11, 32'h0,        32'hA5A5A5A5, 32'h12345678, 32'hA5A5A5A5};
        tv[8]  = '{1'b1, 5'd3,  32'h33,       2'b00, 5'd0,  5'd0,  2'b00, 32'h0,        32'hA5A5A5A5, 32'h12345678, 32'hA5A5A5A5};
        tv[9]  = '{1'b0, 5'd0,  32'h0,        2'b01, 5'd3,  5'd0,  2'b01, 32'h33,       32'hA5A5A5A5, 32'h33,       32'hA5A5A5A5};
        tv[10] = '{1'b0, 5'd0,  32'h0,        2'b00, 5'd0,  5'd0,  2'b00, 32'h33,       32'hA5A5A5A5, 32'h33,       32'hA5A5A5A5};
        tv[11] = '{1'b0, 5'd0,  32'h0,        2'b00, 5'd0,  5'd0,  2'b00, 32'h33,       32'hA5A5A5A5, 32'h33,       32'hA5A5A5A5};
        tv[12] = '{1'b1, 5'd0,  32'hFFFF0000, 2'b01, 5'd0,  5'd0,  2'b01, 32'h0,        32'hA5A5A5A5, 32'h12345678, 32'hA5A5A5A5};
        tv[13] = '{1'b1, 5'd12, 32'hCAFEF00D, 2'b11, 5'd12, 5'd12, 2'b11, 32'hCAFEF00D, 32'hCAFEF00D, 32'h0,        32'h0};
        tv[14] = '{1'b0, 5'd0,  32'h0,        2'b11, 5'd12, 5'd0,  2'b11, 32'hCAFEF00D, 32'h0,        32'hCAFEF00D, 32'hFFFF0000};

        idle();
        // Reads and writes requested while reset is held must be ignored.
        we = 1'b1; waddr = 5'd4; wdata = 32'h44; rd_en = 2'b11;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_a_data", a_rd, 64'h0);
        chk("rst_a_vld", 64'(a_vld), 64'h0);
        chk("rst_b_vld", 64'(b_vld), 64'h0);
        chk("rst_s_data", s_rd, 64'h0);
        @(negedge clock);
        idle();
        ctrl_reset_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            we = tv[i].we; waddr = tv[i].wa; wdata = tv[i].wd;
            rd_en = tv[i].re; raddr = {tv[i].ra1, tv[i].ra0};
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_a_vld", i), 64'(a_vld), 64'(tv[i].ev));
            chk($sformatf("v%0d_b_vld", i), 64'(b_vld), 64'(tv[i].ev));
            chk($sformatf("v%0d_a_d0", i), 64'(a_rd[31:0]), 64'(tv[i].a0));
            chk($sformatf("v%0d_a_d1", i), 64'(a_rd[63:32]), 64'(tv[i].a1));
            chk($sformatf("v%0d_b_d0", i), 64'(b_rd[31:0]), 64'(tv[i].b0));
            chk($sformatf("v%0d_b_d1", i), 64'(b_rd[63:32]), 64'(tv[i].b1));
        end
        @(negedge clock);
        idle();

        // Small instance: fill every entry (entry 0 write is dropped).
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            s_we = 1'b1; s_waddr = 3'(i); s_wdata = 16'h1000 + 16'(i);
        end
        @(negedge clock);
        s_we = 1'b0; s_rd_en = 4'hF; s_raddr = {3'd3, 3'd2, 3'd1, 3'd0};
        @(posedge clock); #1;
        chk("s_rd_lo", s_rd, 64'h1003_1002_1001_0000);
        chk("s_vld_lo", 64'(s_vld), 64'hF);
        @(negedge clock);
        s_raddr = {3'd7, 3'd6, 3'd5, 3'd4};
        @(posedge clock); #1;
        chk("s_rd_hi", s_rd, 64'h1007_1006_1005_1004);
        @(negedge clock);
        s_we = 1'b1; s_waddr = 3'd6; s_wdata = 16'hBEEF; s_raddr = {4{3'd6}};
        @(posedge clock); #1;
        chk("s_bypass_all", s_rd, 64'hBEEF_BEEF_BEEF_BEEF);
        @(negedge clock);
        s_we = 1'b0; s_rd_en = 4'b0010; s_raddr = {3'd0, 3'd0, 3'd6, 3'd0};
        @(posedge clock); #1;
        chk("s_after_bypass", s_rd, 64'hBEEF_BEEF_BEEF_BEEF);
        chk("s_vld_one", 64'(s_vld), 64'h2);

        // Reset between edges with reads pending on every instance.
        @(negedge clock);
        rd_en = 2'b11; raddr = {5'd9, 5'd5};
        s_rd_en = 4'hF; s_raddr = {3'd7, 3'd6, 3'd5, 3'd4};
        @(posedge clock); #1;
        chk("pre_rst_a_d0", 64'(a_rd[31:0]), 64'hDEADBEEF);
        @(negedge clock);
        #2 ctrl_reset_n = 1'b0;
        #1;
        chk("mid_rst_a_data", a_rd, 64'h0);
        chk("mid_rst_a_vld", 64'(a_vld), 64'h0);
        chk("mid_rst_b_data", b_rd, 64'h0);
        chk("mid_rst_b_vld", 64'(b_vld), 64'h0);
        chk("mid_rst_s_data", s_rd, 64'h0);
        chk("mid_rst_s_vld", 64'(s_vld), 64'h0);
        @(posedge clock); #1;
        chk("held_rst_a_vld", 64'(a_vld), 64'h0);
        chk("held_rst_s_vld", 64'(s_vld), 64'h0);
        @(negedge clock);
        ctrl_reset_n = 1'b1;

        for (int a = 0; a < 32; a++) begin
            @(negedge clock);
            rd_en = 2'b11; raddr = {5'(31 - a), 5'(a)};
            s_rd_en = 4'hF; s_raddr = {4{3'(a)}};
            @(posedge clock); #1;
            chk($sformatf("clr_a_%0d", a), a_rd, 64'h0);
            chk($sformatf("clr_b_%0d", a), b_rd, 64'h0);
            chk($sformatf("clr_vld_%0d", a), 64'({a_vld, b_vld}), 64'hF);
            if (a < 8)
                chk($sformatf("clr_s_%0d", a), s_rd, 64'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
